// File: rtl/mod_reduce_arbiter_if.sv
// Client-side request/response bundle for the shared mod-Q reducer arbiter.
// master = requester side, slave = arbiter side.
interface mod_reduce_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int WIDE_W = 64,
  parameter int VEC_W  = 32
);
  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ-1:0][WIDE_W-1:0] req_vec;
  logic [NREQ-1:0]             resp_valid;
  logic [NREQ-1:0]             resp_ready;
  logic [VEC_W-1:0]            resp_vec;

  modport master (
    output req_valid, req_vec, resp_ready,
    input  req_ready, resp_valid, resp_vec
  );

  modport slave (
    input  req_valid, req_vec, resp_ready,
    output req_ready, resp_valid, resp_vec
  );
endinterface

// File: rtl/mod_reduce_arbiter.sv
// Round-robin sharing of one external mod-Q reducer among NREQ clients.
// Owner tags ride a shadow pipeline; one global stall when the output is blocked.
module mod_reduce_arbiter #(
  parameter int  NREQ    = 4,
  parameter int  LAT     = 2,
  parameter int  N_SLOTS = 2,
  parameter int  W_BITS  = 16,
  localparam int TAG_W   = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int WIDE_W  = N_SLOTS * 2 * W_BITS,
  localparam int VEC_W   = N_SLOTS * W_BITS
) (
  input  logic                clk,
  input  logic                reset,
  mod_reduce_arbiter_if.slave bus,
  output logic [WIDE_W-1:0]   red_in_vec,
  output logic                red_en,
  input  logic [VEC_W-1:0]    red_out_vec,
  output logic                busy
);

  logic [TAG_W-1:0]  ptr_reg;
  logic [TAG_W-1:0]  ptr_next;
  logic [TAG_W-1:0]  cand;
  logic [TAG_W-1:0]  grant_idx;
  logic              grant_any;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   req_ready_c;
  logic [NREQ-1:0]   resp_valid_c;
  logic              adv;
  logic              accept;

  logic              slot0_valid_reg;
  logic [TAG_W-1:0]  slot0_tag_reg;
  logic [WIDE_W-1:0] slot0_vec_reg;

  logic              last_valid;
  logic [TAG_W-1:0]  last_tag;
  logic              stage_any;

  logic              out_valid_reg;
  logic [TAG_W-1:0]  out_tag_reg;
  logic [VEC_W-1:0]  out_vec_reg;

  function automatic logic [TAG_W-1:0] wrap_idx(input logic [TAG_W-1:0] base, input int off);
    int sum;
    sum = (int'(base) + off) % NREQ;
    return sum[TAG_W-1:0];
  endfunction

  // Everything moves together unless the output holds an unaccepted result.
  assign adv    = !out_valid_reg || bus.resp_ready[out_tag_reg];
  assign red_en = adv;
  assign accept = adv && grant_any;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = wrap_idx(ptr_reg, k);
      if (!grant_any && bus.req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign ptr_next = accept ? grant_idx : ptr_reg;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_client
      assign req_ready_c[gi]  = !reset && adv && grant[gi];
      assign resp_valid_c[gi] = out_valid_reg && (out_tag_reg == TAG_W'(gi));
    end
  endgenerate

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid_c;
  assign bus.resp_vec   = out_vec_reg;
  assign red_in_vec     = slot0_valid_reg ? slot0_vec_reg : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg         <= TAG_W'(NREQ - 1);
      slot0_valid_reg <= 1'b0;
      slot0_tag_reg   <= '0;
      slot0_vec_reg   <= '0;
    end else begin
      ptr_reg <= ptr_next;
      if (adv) begin
        slot0_valid_reg <= accept;
        slot0_tag_reg   <= grant_idx;
        slot0_vec_reg   <= accept ? bus.req_vec[grant_idx] : '0;
      end
    end
  end

  // Shadow of the reducer's internal registers: tag/valid only, data stays outside.
  generate
    if (LAT == 0) begin : g_comb_reducer
      assign last_valid = slot0_valid_reg;
      assign last_tag   = slot0_tag_reg;
      assign stage_any  = 1'b0;
    end else begin : g_piped_reducer
      logic [LAT-1:0]   stg_valid_reg;
      logic [TAG_W-1:0] stg_tag_reg [LAT];

      always_ff @(posedge clk) begin
        if (reset) begin
          stg_valid_reg <= '0;
          for (int i = 0; i < LAT; i++) begin
            stg_tag_reg[i] <= '0;
          end
        end else if (adv) begin
          stg_valid_reg[0] <= slot0_valid_reg;
          stg_tag_reg[0]   <= slot0_tag_reg;
          for (int i = 1; i < LAT; i++) begin
            stg_valid_reg[i] <= stg_valid_reg[i-1];
            stg_tag_reg[i]   <= stg_tag_reg[i-1];
          end
        end
      end

      assign last_valid = stg_valid_reg[LAT-1];
      assign last_tag   = stg_tag_reg[LAT-1];
      assign stage_any  = |stg_valid_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_tag_reg   <= '0;
      out_vec_reg   <= '0;
    end else if (adv) begin
      out_valid_reg <= last_valid;
      out_tag_reg   <= last_tag;
      out_vec_reg   <= red_out_vec;
    end
  end

  assign busy = slot0_valid_reg || stage_any || out_valid_reg;

endmodule

// File: tb/tb_mod_reduce_arbiter.sv
// Directed bench for mod_reduce_arbiter: LAT=2 and LAT=0 instances, each driving
// a behavioural mod-3329 reducer model that advances on red_en.
module tb_mod_reduce_arbiter;
  localparam int NREQ   = 4;
  localparam int N_SLOTS = 2;
  localparam int W_BITS = 16;
  localparam int WIDE_W = 64;
  localparam int VEC_W  = 32;
  localparam int Q_MOD  = 3329;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mod_reduce_arbiter_if #(.NREQ(NREQ), .WIDE_W(WIDE_W), .VEC_W(VEC_W)) bus0 ();
  mod_reduce_arbiter_if #(.NREQ(NREQ), .WIDE_W(WIDE_W), .VEC_W(VEC_W)) bus1 ();

  logic [WIDE_W-1:0] red_in0, red_in1;
  logic              red_en0, red_en1;
  logic [VEC_W-1:0]  red_out0, red_out1;
  logic              busy0, busy1;

  function automatic logic [VEC_W-1:0] reduce(input logic [WIDE_W-1:0] w);
    logic [VEC_W-1:0] r;
    int v;
    int m;
    r = '0;
    for (int s = 0; s < N_SLOTS; s++) begin
      v = $signed(w[s*32 +: 32]);
      m = v % Q_MOD;
      if (m < 0) m = m + Q_MOD;
      r[s*16 +: 16] = m[15:0];
    end
    return r;
  endfunction

  logic [VEC_W-1:0] red_p1 = '0;
  logic [VEC_W-1:0] red_p2 = '0;
  always @(posedge clk) begin
    if (red_en0) begin
      red_p1 <= reduce(red_in0);
      red_p2 <= red_p1;
    end
  end
  assign red_out0 = red_p2;
  assign red_out1 = reduce(red_in1);

  mod_reduce_arbiter #(.NREQ(NREQ), .LAT(2), .N_SLOTS(N_SLOTS), .W_BITS(W_BITS)) u_dut2 (
    .clk(clk), .reset(reset), .bus(bus0),
    .red_in_vec(red_in0), .red_en(red_en0), .red_out_vec(red_out0), .busy(busy0)
  );

  mod_reduce_arbiter #(.NREQ(NREQ), .LAT(0), .N_SLOTS(N_SLOTS), .W_BITS(W_BITS)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus1),
    .red_in_vec(red_in1), .red_en(red_en1), .red_out_vec(red_out1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [63:0] mk(input int a, input int b);
    return {b[31:0], a[31:0]};
  endfunction

  function automatic logic [31:0] nv(input int a, input int b);
    return {b[15:0], a[15:0]};
  endfunction

  function automatic logic [3:0] onehot(input int k);
    return 4'(1 << k);
  endfunction

  int          g_hist [32];
  int          id;
  int          eg;
  logic [3:0]  mask;
  logic [3:0]  exp_rv;

  initial begin
    reset = 1'b1;
    bus0.req_valid = '0; bus0.req_vec = '0; bus0.resp_ready = '1;
    bus1.req_valid = '0; bus1.req_vec = '0; bus1.resp_ready = '1;
    tick();
    tick();

    // Reset state, with every client already asking
    bus0.req_valid = 4'hF;
    #1;
    chk("rst_req_ready", bus0.req_ready, 4'h0);
    chk("rst_resp_valid", bus0.resp_valid, 4'h0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_resp_vec", bus0.resp_vec, 32'h0);
    chk("rst_red_in", red_in0, 64'h0);

    // Single all-ones vector from client 2: every slot reduces to Q-1
    reset = 1'b0;
    bus0.req_valid = 4'b0100;
    bus0.req_vec[2] = '1;
    #1;
    chk("t1_grant", bus0.req_ready, 4'b0100);
    tick();
    bus0.req_valid = '0;
    #1;
    chk("t1_busy_a1", busy0, 1'b1);
    chk("t1_red_in", red_in0, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int k = 2; k <= 3; k++) begin
      tick();
      chk("t1_busy_mid", busy0, 1'b1);
      chk("t1_resp_early", bus0.resp_valid, 4'h0);
    end
    tick();
    chk("t1_resp_valid", bus0.resp_valid, 4'b0100);
    chk("t1_resp_vec", bus0.resp_vec, {16'd3328, 16'd3328});
    chk("t1_busy_resp", busy0, 1'b1);
    tick();
    chk("t1_busy_after", busy0, 1'b0);
    chk("t1_resp_after", bus0.resp_valid, 4'h0);

    // All four clients requesting: round-robin grants and FIFO responses
    do_reset();
    for (int c = 0; c < NREQ; c++) bus0.req_vec[c] = mk(c, 100 + c);
    for (int k = 0; k < 12; k++) begin
      bus0.req_valid = (k < 6) ? 4'hF : 4'h0;
      #1;
      chk("t2_grant", bus0.req_ready, (k < 6) ? onehot(k % 4) : 4'h0);
      if (k >= 4 && k < 10) begin
        chk("t2_resp_valid", bus0.resp_valid, onehot((k - 4) % 4));
        chk("t2_resp_vec", bus0.resp_vec, nv((k - 4) % 4, 100 + (k - 4) % 4));
      end else begin
        chk("t2_resp_idle", bus0.resp_valid, 4'h0);
      end
      tick();
    end

    // Full pipeline, client 0 withholds resp_ready for 5 cycles
    do_reset();
    mask = 4'hF;
    for (int k = 0; k < 15; k++) begin
      bus0.req_valid  = mask;
      bus0.resp_ready = (k >= 4 && k <= 8) ? 4'hE : 4'hF;
      #1;
      chk("t3_grant", bus0.req_ready, (k < 4) ? onehot(k) : 4'h0);
      chk("t3_red_en", red_en0, (k >= 4 && k <= 8) ? 1'b0 : 1'b1);
      exp_rv = (k >= 4 && k <= 9) ? 4'b0001 : ((k >= 10 && k <= 12) ? onehot(k - 9) : 4'h0);
      chk("t3_resp_valid", bus0.resp_valid, exp_rv);
      if (exp_rv != 4'h0) begin
        id = (k <= 9) ? 0 : k - 9;
        chk("t3_resp_vec", bus0.resp_vec, nv(id, 100 + id));
      end
      if (k >= 4 && k <= 8) chk("t3_red_in_hold", red_in0, mk(3, 103));
      if (k == 13) chk("t3_busy_drained", busy0, 1'b0);
      if (k < 4) mask = mask & ~onehot(k);
      tick();
    end

    // Three in flight, then a one-cycle reset discards them
    for (int k = 0; k < 3; k++) begin
      bus0.req_valid = 4'hF;
      #1;
      chk("t4_grant", bus0.req_ready, onehot(k));
      tick();
    end
    reset = 1'b1;
    #1;
    chk("t4_rst_ready", bus0.req_ready, 4'h0);
    tick();
    reset = 1'b0;
    #1;
    chk("t4_resp_valid", bus0.resp_valid, 4'h0);
    chk("t4_busy", busy0, 1'b0);
    chk("t4_first_grant", bus0.req_ready, 4'b0001);
    bus0.req_valid = '0;
    tick();
    tick();
    chk("t4_busy_later", busy0, 1'b0);
    chk("t4_no_resp", bus0.resp_valid, 4'h0);
    tick();
    tick();
    chk("t4_no_resp_late", bus0.resp_valid, 4'h0);

    // Client 1 streaming, client 3 joins at cycle 10: alternation 3,1,3,1
    for (int k = 0; k < 20; k++) begin
      bus0.req_valid = (k >= 16) ? 4'b0000 : ((k >= 10) ? 4'b1010 : 4'b0010);
      #1;
      if (k < 16) begin
        eg = (k >= 10 && ((k - 10) % 2) == 0) ? 3 : 1;
        g_hist[k] = eg;
        chk("t6_grant", bus0.req_ready, onehot(eg));
      end else begin
        chk("t6_grant_idle", bus0.req_ready, 4'h0);
      end
      if (k >= 4) begin
        chk("t6_resp_valid", bus0.resp_valid, onehot(g_hist[k - 4]));
        chk("t6_resp_vec", bus0.resp_vec, nv(g_hist[k - 4], 100 + g_hist[k - 4]));
      end
      tick();
    end
    tick();
    chk("t6_busy_drained", busy0, 1'b0);

    // LAT=0 instance: single request, then a back-to-back stream from client 2
    bus1.req_vec[0] = mk(5, 6);
    bus1.req_valid = 4'b0001;
    #1;
    chk("t5_grant", bus1.req_ready, 4'b0001);
    tick();
    bus1.req_valid = '0;
    #1;
    chk("t5_resp_early", bus1.resp_valid, 4'h0);
    tick();
    chk("t5_resp_valid", bus1.resp_valid, 4'b0001);
    chk("t5_resp_vec", bus1.resp_vec, nv(5, 6));
    tick();
    chk("t5_busy_after", busy1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      bus1.req_valid = (k < 4) ? 4'b0100 : 4'h0;
      bus1.req_vec[2] = mk(10 + k, 20 + k);
      #1;
      chk("t5_stream_grant", bus1.req_ready, (k < 4) ? 4'b0100 : 4'h0);
      if (k >= 2 && k < 6) begin
        chk("t5_stream_valid", bus1.resp_valid, 4'b0100);
        chk("t5_stream_vec", bus1.resp_vec, nv(8 + k, 18 + k));
      end else begin
        chk("t5_stream_idle", bus1.resp_valid, 4'h0);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mod_reduce_arbiter.md
Name: mod_reduce_arbiter

Overview:
Round-robin scheduler that shares one modular-reduction datapath (a wide_vec_t -> vec_t mod-Q reducer, optionally retimed into LAT register stages) among NREQ requesters. It accepts wide products over per-client valid/ready, issues at most one vector per cycle into the reducer, and tracks the owner tag through the reducer pipeline. Each reduced vector returns to its owner over per-client valid/ready. A single global stall applies when the output is back-pressured. It sits between the NTT/multiply units and the shared reducer.

Parameters:
NREQ, 4, number of requesters (>=2)
LAT, 2, register stages inside the external reducer (0 = purely combinational reducer)
TAG_W, $clog2(NREQ), owner tag width (derived; do not override)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req_valid  input  NREQ  per-client request valid
req_ready  output  NREQ  per-client accept; at most one bit high
req_vec  input  NREQ x wide_vec_t  per-client signed wide vector (N_SLOTS_L slots of 2*W_BITS_L)
resp_valid  output  NREQ  per-client result valid; at most one bit high
resp_ready  input  NREQ  per-client result accept
resp_vec  output  vec_t  reduced vector, qualified by resp_valid
red_in_vec  output  wide_vec_t  operand to shared reducer
red_en  output  1  advance enable for reducer pipeline registers
red_out_vec  input  vec_t  reducer result, LAT cycles after red_in_vec under red_en
busy  output  1  any valid entry in slot0, tag pipeline or output register

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset: all stage valids 0, resp_valid 0, req_ready 0, resp_vec 0, red_in_vec 0, busy 0, RR pointer = NREQ-1, so client 0 has first priority. Reset mid-operation discards all in-flight entries with no response.
- Internal storage:
  - slot0: registered operand plus tag plus valid; drives red_in_vec, which is 0 when slot0 is invalid.
  - Tag/valid shift register of LAT stages, mirroring the reducer.
  - Output register: resp_vec, out_tag, out_valid.
- Advance: adv = !out_valid || resp_ready[out_tag]. red_en = adv. Slot0, the tag stages and the output register shift only when adv=1. The output register loads red_out_vec, tag and valid from the last stage (or from slot0 when LAT=0).
- Arbitration is combinational each cycle. Grant goes to the first i with req_valid[i]=1, scanning from pointer+1 modulo NREQ.
  - req_ready[i] = adv && grant[i].
  - On a handshake: slot0 captures req_vec[i] and tag i, and pointer := i.
  - If no request is accepted while adv=1, slot0 loads a bubble (valid 0). Pointer holds whenever no handshake occurs.
- Requester rules: clients hold req_valid and req_vec stable until accepted. req_ready may depend on req_valid. A client must not make req_valid depend on req_ready.
- Latency: accept in cycle t -> resp_valid[tag] high in cycle t+LAT+2 when unstalled. Throughput is one vector per cycle.
- Response: resp_valid[k] = out_valid && out_tag==k. Output is held stable until resp_ready[k].
- Simultaneous handshake and output load: a resp handshake and an output-register load in the same cycle are legal and lossless.
- Stall: while out_valid && !resp_ready[out_tag], nothing moves. red_en=0, all req_ready=0, and all registers hold. No entry is dropped or duplicated.
- Ordering: responses leave in acceptance order (global FIFO order). A stalled client blocks all others.
- busy = OR of slot0 valid, all stage valids and out_valid.
- Arithmetic: the block does no arithmetic on data; vectors pass bit-exact. Tag compare is TAG_W wide.

Test Plan:
- Reset, then client 2 sends one vector with every slot = -1 (all ones, 2W bits), resp_ready=all 1, LAT=2 -> resp_valid=4'b0100 exactly 4 cycles after the accept, every slot = Q_MOD_L-1; busy high from the cycle after accept until the response handshake.
- All 4 clients hold req_valid, each vector tagged by slot0=client id, resp_ready=all 1 -> grants 0,1,2,3,0,1 on consecutive cycles; responses arrive in the same order, one per cycle.
- Pipeline full, resp_ready[0]=0 for 5 cycles -> red_en=0, req_ready=0, resp_vec and red_in_vec constant; after release the remaining entries drain in order with no loss or duplicate.
- Three entries in flight, reset asserted for 1 cycle -> next cycle resp_valid=0 and busy=0; with all clients requesting, client 0 is granted first.
- LAT=0 build (combinational reducer) -> single request yields resp_valid 2 cycles after accept; back-to-back stream sustains 1 per cycle.
- Client 1 requests continuously, client 3 raises req_valid at cycle 10 -> client 3 is granted within 2 cycles; grants then alternate 1,3,1,3.
